// File: rtl/ram_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_loader
// Description : Framed byte-stream bus master. Parses a little-endian header
//               (base word address, word count) and writes the following
//               data words into RAM through one wrapper port. Flags writes
//               that miss the wrapper's decoded window and aborts on stream
//               stalls. Holds the CPU (busy) while a frame is loading.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_loader #(
    parameter int PBITS   = 32,
    parameter int DBITS   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic [PBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_data,
    input  logic             mem_act,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    input  logic             err_clr
);

    localparam int c_NBYTES = DBITS / 8;
    // Byte index must count the 4 header bytes as well as the data lanes.
    localparam int c_IW     = (c_NBYTES > 4) ? $clog2(c_NBYTES) : 2;
    localparam int c_TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [c_IW-1:0] c_LAST_HDR  = c_IW'(3);
    localparam logic [c_IW-1:0] c_LAST_DATA = c_IW'(c_NBYTES - 1);
    localparam logic [1:0]      c_ERR_NONE  = 2'd0;
    localparam logic [1:0]      c_ERR_RANGE = 2'd1;
    localparam logic [1:0]      c_ERR_TMO   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CNT  = 3'd2,
        S_DATA = 3'd3,
        S_WR   = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_idx;     // byte position within the current field
    logic [23:0]       r_hdr;     // lower three bytes of the header field
    logic [31:0]       r_cnt;     // words still to be written
    logic [c_TW-1:0]   r_idle;    // cycles since the last accepted byte

    logic              w_xfer;
    logic [31:0]       w_hdr_word;
    logic              w_timeout;
    logic              w_miss;

    assign w_xfer     = in_valid & in_ready;
    // Completed header field: incoming byte is the most significant one.
    assign w_hdr_word = {in_data, r_hdr};
    assign w_timeout  = (TIMEOUT != 0) && !w_xfer &&
                        (r_idle == c_TW'(TIMEOUT - 1)) &&
                        ((r_state == S_ADDR) || (r_state == S_CNT) || (r_state == S_DATA));
    assign w_miss     = (r_state == S_WR) && !mem_act;

    // Frame parser, write sequencer, stall timer and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_hdr    <= '0;
            r_cnt    <= '0;
            r_idle   <= '0;
            in_ready <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= c_ERR_NONE;
        end else begin
            done <= 1'b0;

            // A new error beats a same-cycle clear; a range miss never
            // downgrades a pending timeout.
            if (w_timeout)
                err <= c_ERR_TMO;
            else if (w_miss && (err_clr || (err != c_ERR_TMO)))
                err <= c_ERR_RANGE;
            else if (err_clr)
                err <= c_ERR_NONE;

            // The write cycle is the loader's own stall, so it is not counted.
            if ((TIMEOUT == 0) || (r_state == S_IDLE) || w_xfer)
                r_idle <= '0;
            else if (r_state != S_WR)
                r_idle <= r_idle + c_TW'(1);

            if (w_xfer)
                r_hdr <= {in_data, r_hdr[23:8]};

            case (r_state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (w_xfer) begin
                        r_idx   <= c_IW'(1);
                        r_state <= S_ADDR;
                        busy    <= 1'b1;
                    end
                end

                S_ADDR: begin
                    if (w_timeout) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        r_idx   <= '0;
                    end else if (w_xfer) begin
                        if (r_idx == c_LAST_HDR) begin
                            mem_addr <= PBITS'(w_hdr_word);
                            r_idx    <= '0;
                            r_state  <= S_CNT;
                        end else begin
                            r_idx <= r_idx + c_IW'(1);
                        end
                    end
                end

                S_CNT: begin
                    if (w_timeout) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        r_idx   <= '0;
                    end else if (w_xfer) begin
                        if (r_idx == c_LAST_HDR) begin
                            r_idx <= '0;
                            if (w_hdr_word == 32'd0) begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                r_cnt   <= w_hdr_word;
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_idx <= r_idx + c_IW'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (w_timeout) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        r_idx   <= '0;
                    end else if (w_xfer) begin
                        mem_data[8*r_idx +: 8] <= in_data;
                        if (r_idx == c_LAST_DATA) begin
                            r_idx    <= '0;
                            in_ready <= 1'b0;
                            mem_en   <= 1'b1;
                            mem_we   <= 1'b1;
                            r_state  <= S_WR;
                        end else begin
                            r_idx <= r_idx + c_IW'(1);
                        end
                    end
                end

                S_WR: begin
                    // Address wraps silently past the top of the port space.
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    in_ready <= 1'b1;
                    mem_addr <= mem_addr + PBITS'(1);
                    r_cnt    <= r_cnt - 32'd1;
                    if (r_cnt == 32'd1) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state <= S_DATA;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_stream_loader
// Description : Self-checking bench for ram_stream_loader. Table-driven
//               frames, randomized frames against a frame-level model, and
//               hand sequences for zero-count, timeout and reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_stream_loader;

    localparam int PBITS   = 32;
    localparam int DBITS   = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_en;
    logic              mem_we;
    logic [PBITS-1:0]  mem_addr;
    logic [DBITS-1:0]  mem_data;
    logic              mem_act;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic              err_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         got_q[$];
    wr_t         exp_q[$];
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [1:0]  model_err = 2'd0;

    typedef struct {
        string             name;
        logic [31:0]       base;
        logic [31:0]       n;
        logic [3:0][31:0]  w;
        logic [1:0]        exp_err;
    } vec_t;

    vec_t vecs[4];

    ram_stream_loader #(
        .PBITS   (PBITS),
        .DBITS   (DBITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_act  (mem_act),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    // Decoded RAM window of the wrapper: bottom and top 64K words.
    function automatic logic in_window(input logic [31:0] a);
        return (a < 32'h0001_0000) || (a >= 32'hFFFF_0000);
    endfunction

    assign mem_act = in_window(mem_addr);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write/done monitor on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_en) got_q.push_back({mem_addr, mem_data});
            if (done) done_cnt++;
            if (mem_en || mem_we) check("we_eq_en", 64'(mem_we), 64'(mem_en));
        end
    end

    // Called and returns just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check("ready_wait", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Stream a whole frame and record what the RAM should see.
    task automatic send_frame(input logic [31:0] base, input logic [31:0] n, input logic [31:0] words[$]);
        logic miss;
        miss = 1'b0;
        send_word(base);
        send_word(n);
        for (int i = 0; i < int'(n); i++) send_word(words[i]);
        in_valid = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({base + 32'(i), words[i]});
            if (!in_window(base + 32'(i))) miss = 1'b1;
        end
        if (miss) model_err = 2'd1;
        exp_done++;
    endtask

    task automatic finish_frame(input string nm);
        repeat (3) @(negedge clk);
        check({nm, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({nm, "_addr"}, 64'(got_q[i].a), 64'(exp_q[i].a));
            check({nm, "_data"}, 64'(got_q[i].d), 64'(exp_q[i].d));
        end
        check({nm, "_done"}, 64'(done_cnt), 64'(exp_done));
        check({nm, "_busy"}, 64'(busy), 64'd0);
        check({nm, "_err"}, 64'(err), 64'(model_err));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_err = 2'd0;
        check("err_clr", 64'(err), 64'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_in_ready"}, 64'(in_ready), 64'd0);
        check({nm, "_mem_en"},   64'(mem_en),   64'd0);
        check({nm, "_mem_we"},   64'(mem_we),   64'd0);
        check({nm, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({nm, "_mem_data"}, 64'(mem_data), 64'd0);
        check({nm, "_busy"},     64'(busy),     64'd0);
        check({nm, "_done"},     64'(done),     64'd0);
        check({nm, "_err"},      64'(err),      64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] words[$];
        logic [31:0] base, n;

        vecs[0] = '{"basic",  32'h0000_1000, 32'd2, {32'h0, 32'h0, 32'h5566_7788, 32'h1122_3344}, 2'd0};
        vecs[1] = '{"zero_n", 32'h0000_0020, 32'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 2'd0};
        vecs[2] = '{"wrap",   32'hFFFF_FFFF, 32'd2, {32'h0, 32'h0, 32'hCAFE_F00D, 32'hDEAD_BEEF}, 2'd0};
        vecs[3] = '{"miss",   32'h8000_0000, 32'd3, {32'h0, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001}, 2'd1};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            words.delete();
            for (int i = 0; i < int'(vecs[v].n); i++) words.push_back(vecs[v].w[i]);
            send_frame(vecs[v].base, vecs[v].n, words);
            finish_frame(vecs[v].name);
            check({vecs[v].name, "_tbl_err"}, 64'(err), 64'(vecs[v].exp_err));
        end
        clear_err();

        // Zero-count frame: done exactly one cycle after the last count byte
        send_word(32'h0000_0040);
        send_word(32'h0);
        in_valid = 1'b0;
        exp_done++;
        check("n0_done_hi", 64'(done), 64'd1);
        @(negedge clk);
        check("n0_done_lo", 64'(done), 64'd0);
        finish_frame("n0");

        // Timeout: stall after 6 header bytes
        send_word(32'h0000_0100);
        send_byte(8'h05);
        send_byte(8'h00);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("tmo_busy_hold", 64'(busy), 64'd1);
        @(negedge clk);
        check("tmo_busy_drop", 64'(busy), 64'd0);
        check("tmo_err", 64'(err), 64'd2);
        model_err = 2'd2;
        words = '{32'h0BAD_F00D};
        send_frame(32'h0000_0010, 32'd1, words);
        finish_frame("after_tmo");
        clear_err();

        // Asynchronous reset in the middle of a data word
        send_word(32'h0000_2000);
        send_word(32'd2);
        send_byte(8'h77);
        send_byte(8'h66);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        done_cnt  = 0;
        exp_done  = 0;
        model_err = 2'd0;
        @(negedge clk);
        words = '{32'h1357_9BDF, 32'h2468_ACE0};
        send_frame(32'h0000_3000, 32'd2, words);
        finish_frame("after_rst");

        // Randomized frames against the frame-level model
        for (int f = 0; f < 20; f++) begin
            case ($urandom_range(0, 2))
                0:       base = 32'($urandom_range(0, 32'hFF00));
                1:       base = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: base = 32'h4000_0000 + 32'($urandom_range(0, 255));
            endcase
            n = 32'($urandom_range(0, 4));
            words.delete();
            for (int i = 0; i < int'(n); i++) words.push_back($urandom);
            send_frame(base, n, words);
            finish_frame("rand");
            if (f % 5 == 4) clear_err();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
